// File: rtl/updown_counter.sv
// Free-running WIDTH-bit up/down counter with a combinational terminal-count flag.
// Define COUNTER_SAT_EN to hold at the limits instead of wrapping.
module updown_counter #(
  parameter int unsigned           WIDTH   = 4,
  parameter logic [WIDTH-1:0]      RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             up_down,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_VAL = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             at_limit_s;

  // Terminal value depends on the direction currently requested.
  always_comb begin
    at_limit_s = 1'b0;
    if (up_down) begin
      at_limit_s = (cnt_q == MAX_VAL);
    end else begin
      at_limit_s = (cnt_q == MIN_VAL);
    end
  end

  // Next-state step; arithmetic wraps naturally at WIDTH bits.
  always_comb begin
    cnt_d = cnt_q;
`ifdef COUNTER_SAT_EN
    if (at_limit_s) begin
      cnt_d = cnt_q;
    end else if (up_down) begin
      cnt_d = cnt_q + ONE_VAL;
    end else begin
      cnt_d = cnt_q - ONE_VAL;
    end
`else
    if (up_down) begin
      cnt_d = cnt_q + ONE_VAL;
    end else begin
      cnt_d = cnt_q - ONE_VAL;
    end
`endif
  end

  // Count register with synchronous active-low reset taking priority.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = at_limit_s;

endmodule

// File: tb/tb_updown_counter.sv
// Directed self-checking bench for updown_counter: a 4-bit and an 8-bit instance.
module tb_updown_counter;

  logic       clk;
  logic       n_rst4, up4, tc4;
  logic [3:0] cnt4;
  logic       n_rst8, up8, tc8;
  logic [7:0] cnt8;

  int checks = 0;
  int errors = 0;

  updown_counter #(.WIDTH(4)) dut4 (
    .clk(clk), .n_rst(n_rst4), .up_down(up4), .cnt(cnt4), .tc(tc4)
  );

  updown_counter #(.WIDTH(8)) dut8 (
    .clk(clk), .n_rst(n_rst8), .up_down(up8), .cnt(cnt8), .tc(tc8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset4(input logic dir);
    @(negedge clk);
    up4    = dir;
    n_rst4 = 1'b0;
    edge_settle();
    edge_settle();
    @(negedge clk);
    n_rst4 = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    up4    = 1'b1;
    n_rst4 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      edge_settle();
      checks++;
      if (cnt4 !== 4'd0) begin
        errors++;
        $display("FAIL reset_cnt cycle %0d got %0d want 0", i, cnt4);
      end
      checks++;
      if (tc4 !== 1'b0) begin
        errors++;
        $display("FAIL reset_tc_up got %b want 0", tc4);
      end
    end
    @(negedge clk);
    up4 = 1'b0;
    #1;
    checks++;
    if (tc4 !== 1'b1) begin
      errors++;
      $display("FAIL reset_tc_down got %b want 1", tc4);
    end
  endtask

  task automatic test_up_count();
    logic [3:0] exp;
    reset4(1'b1);
    for (int i = 1; i <= 18; i++) begin
      edge_settle();
`ifdef COUNTER_SAT_EN
      exp = (i > 15) ? 4'd15 : i[3:0];
`else
      exp = i[3:0];
`endif
      checks++;
      if (cnt4 !== exp) begin
        errors++;
        $display("FAIL up_cnt step %0d got %0d want %0d", i, cnt4, exp);
      end
      checks++;
      if (tc4 !== (exp == 4'd15)) begin
        errors++;
        $display("FAIL up_tc step %0d got %b want %b", i, tc4, exp == 4'd15);
      end
    end
  endtask

  task automatic test_down_count();
    logic [3:0] exp;
    reset4(1'b0);
    for (int i = 1; i <= 18; i++) begin
      edge_settle();
`ifdef COUNTER_SAT_EN
      exp = 4'd0;
`else
      exp = 4'((32 - i) % 16);
`endif
      checks++;
      if (cnt4 !== exp) begin
        errors++;
        $display("FAIL down_cnt step %0d got %0d want %0d", i, cnt4, exp);
      end
      checks++;
      if (tc4 !== (exp == 4'd0)) begin
        errors++;
        $display("FAIL down_tc step %0d got %b want %b", i, tc4, exp == 4'd0);
      end
    end
  endtask

  task automatic test_mid_reset();
    reset4(1'b1);
    for (int i = 0; i < 7; i++) edge_settle();
    checks++;
    if (cnt4 !== 4'd7) begin
      errors++;
      $display("FAIL mid_pre got %0d want 7", cnt4);
    end
    @(negedge clk);
    n_rst4 = 1'b0;
    #1;
    checks++;
    if (cnt4 !== 4'd7) begin
      errors++;
      $display("FAIL mid_async got %0d want 7", cnt4);
    end
    for (int i = 0; i < 2; i++) begin
      edge_settle();
      checks++;
      if (cnt4 !== 4'd0) begin
        errors++;
        $display("FAIL mid_hold edge %0d got %0d want 0", i, cnt4);
      end
    end
  endtask

  task automatic test_reversal();
    logic [3:0] exp_seq [5];
    exp_seq = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    reset4(1'b1);
    for (int i = 0; i < 5; i++) edge_settle();
    checks++;
    if (cnt4 !== 4'd5) begin
      errors++;
      $display("FAIL rev_pre got %0d want 5", cnt4);
    end
    @(negedge clk);
    up4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      edge_settle();
      checks++;
      if (cnt4 !== exp_seq[i]) begin
        errors++;
        $display("FAIL rev_cnt step %0d got %0d want %0d", i, cnt4, exp_seq[i]);
      end
    end
    checks++;
    if (tc4 !== 1'b1) begin
      errors++;
      $display("FAIL rev_tc_down0 got %b want 1", tc4);
    end
    @(negedge clk);
    up4 = 1'b1;
    #1;
    checks++;
    if (tc4 !== 1'b0) begin
      errors++;
      $display("FAIL rev_tc_up0 got %b want 0", tc4);
    end
    edge_settle();
    checks++;
    if (cnt4 !== 4'd1) begin
      errors++;
      $display("FAIL rev_up_step got %0d want 1", cnt4);
    end
  endtask

`ifdef COUNTER_SAT_EN
  task automatic test_saturation();
    logic [3:0] exp;
    reset4(1'b1);
    for (int i = 1; i <= 20; i++) begin
      edge_settle();
      exp = (i > 15) ? 4'd15 : i[3:0];
      checks++;
      if (cnt4 !== exp) begin
        errors++;
        $display("FAIL sat_cnt step %0d got %0d want %0d", i, cnt4, exp);
      end
    end
    checks++;
    if (tc4 !== 1'b1) begin
      errors++;
      $display("FAIL sat_tc got %b want 1", tc4);
    end
    @(negedge clk);
    up4 = 1'b0;
    edge_settle();
    checks++;
    if (cnt4 !== 4'd14) begin
      errors++;
      $display("FAIL sat_rev1 got %0d want 14", cnt4);
    end
    edge_settle();
    checks++;
    if (cnt4 !== 4'd13) begin
      errors++;
      $display("FAIL sat_rev2 got %0d want 13", cnt4);
    end
  endtask
`endif

  task automatic test_width8();
    logic [7:0] exp;
    @(negedge clk);
    up8    = 1'b1;
    n_rst8 = 1'b0;
    edge_settle();
    checks++;
    if (cnt8 !== 8'd0) begin
      errors++;
      $display("FAIL w8_reset got %0d want 0", cnt8);
    end
    @(negedge clk);
    n_rst8 = 1'b1;
    for (int i = 1; i <= 260; i++) begin
      edge_settle();
`ifdef COUNTER_SAT_EN
      exp = (i > 255) ? 8'd255 : i[7:0];
`else
      exp = i[7:0];
`endif
      checks++;
      if (cnt8 !== exp || tc8 !== (exp == 8'd255)) begin
        errors++;
        $display("FAIL w8_step %0d got cnt=%0d tc=%b want cnt=%0d tc=%b",
                 i, cnt8, tc8, exp, exp == 8'd255);
      end
    end
  endtask

  initial begin
    n_rst4 = 1'b0;
    up4    = 1'b1;
    n_rst8 = 1'b0;
    up8    = 1'b1;
    test_reset();
    test_up_count();
    test_down_count();
    test_mid_reset();
    test_reversal();
`ifdef COUNTER_SAT_EN
    test_saturation();
`endif
    test_width8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_counter.md
Name: updown_counter

Overview:
- Free-running, parameterizable binary up/down counter. Default width is 4 bits.
- Direction is selected every cycle by a single control input.
- Counts on every clock edge when out of reset; wraps modulo 2^WIDTH.
- Serves as a general-purpose sequencing and test block, with a terminal-count flag for chaining or event detection.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..32.
- RST_VAL, 0, value loaded into cnt during reset; must fit in WIDTH bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- n_rst  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
- up_down  input  1  direction select: 1 = count up, 0 = count down.
- cnt  output  WIDTH  current count, driven directly from a register.
- tc  output  1  terminal count; combinational from cnt and up_down.

Interface (already decided):
- One clock, clk.
- Reset is synchronous and active-low, port n_rst.

Behaviour:
- Every rising edge of clk:
  - If n_rst == 0: cnt <= RST_VAL (default 0), regardless of up_down.
  - Else if up_down == 1: cnt <= cnt + 1 mod 2^WIDTH.
  - Else: cnt <= cnt - 1 mod 2^WIDTH.
- No enable or hold input; the counter changes state every non-reset cycle.
- Latency:
  - up_down is sampled on the same edge that applies the step.
  - A direction change takes effect on the first edge after it is applied. There is no extra pipeline delay.
- Wrap-around:
  - Up: 2^WIDTH-1 -> 0 (4-bit: 15 -> 0).
  - Down: 0 -> 2^WIDTH-1 (4-bit: 0 -> 15).
- tc:
  - 1 when (up_down == 1 and cnt == 2^WIDTH-1) or (up_down == 0 and cnt == 0); else 0.
  - Purely combinational, so it can toggle within a cycle if up_down changes.
  - tc is 0 during reset only if RST_VAL does not match the terminal value for the current direction. With the default RST_VAL = 0 and up_down = 0, tc = 1 while in reset.
- Reset timing:
  - Reset is not asynchronous: asserting n_rst between edges has no effect until the next rising edge.
  - Reset asserted mid-count forces RST_VAL on the next edge, in either direction.
  - On release, the first step occurs on the first rising edge at which n_rst is sampled 1.
- Reset and up_down together: reset has priority over counting.
- Power-up: cnt is X until the first reset edge. The bench must apply reset before checking.
- Fully synthesizable: one register bank plus an adder/subtractor; no latches.

Optional Feature:
- Macro COUNTER_SAT_EN.
- When defined: saturating mode.
  - Counting up holds at 2^WIDTH-1 instead of wrapping.
  - Counting down holds at 0 instead of wrapping.
  - tc is unchanged in definition; it stays 1 while the counter is held at the limit.
  - Reversing direction while saturated resumes counting on the next edge (e.g. 15, up_down -> 0, gives 14).
- When undefined (default): modulo wrap-around as described in Behaviour.

Test Plan:
- Reset then up count: up_down=1, n_rst=0 for 2 cycles, release at negedge, run 18 cycles -> cnt = 0 during reset, then 1,2,...,15,0,1,2 on successive edges; tc=1 only while cnt=15.
- Reset then down count: up_down=0, n_rst=0 for 2 cycles, release, run 18 cycles -> cnt = 0 during reset, then 15,14,...,1,0,15,14; tc=1 only while cnt=0.
- Mid-count reset: counting up at cnt=7, drive n_rst=0 between edges -> cnt stays 7 until the next rising edge, then becomes 0; holds 0 while n_rst=0.
- Direction reversal: at cnt=5 counting up, set up_down=0 before the edge -> next values 4,3,2; tc toggles combinationally with up_down at the boundaries.
- Saturation (COUNTER_SAT_EN defined): count up from 0 for 20 cycles -> cnt reaches 15 and holds 15, tc=1; switch to down -> 14,13.
- Width parameter: WIDTH=8, up for 260 cycles from reset -> wrap 255 -> 0 at cycle 256; tc asserted exactly at cnt=255.
